// File: rtl/flash_arb_pkg.sv
// Shared types and defaults for flash_read_arbiter and its wait timer.
// Arbitration policy is chosen in the top by FLASH_ARB_AUD_PRIORITY_EN.
package flash_arb_pkg;

   typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, DONE} state_t;
   typedef enum logic {AUD = 1'b0, GFX = 1'b1} owner_t;

   localparam int ADDR_W_DEFAULT      = 23;
   localparam int WAIT_CYCLES_DEFAULT = 4;
   localparam int TIMER_W             = 4;

   // Round-robin pick: on a tie the requester that did not win last time goes next.
   function automatic owner_t rr_pick(input logic aud_req, input logic gfx_req,
                                      input owner_t last_grant);
      owner_t w;
      if (aud_req && gfx_req) w = (last_grant == AUD) ? GFX : AUD;
      else if (gfx_req)       w = GFX;
      else                    w = AUD;
      return w;
   endfunction

endpackage

// File: rtl/flash_wait_timer.sv
// Loadable down-counter timing one flash byte access; o_done marks the last wait cycle.
module flash_wait_timer
   import flash_arb_pkg::*;
#(
   parameter int CNT_W = TIMER_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_done
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                    r_cnt <= '0;
      else if (i_load)                 r_cnt <= i_load_val;
      else if (i_en && r_cnt != '0)    r_cnt <= r_cnt - CNT_W'(1);
   end

   assign o_done = i_en && (r_cnt == '0);

endmodule

// File: rtl/flash_read_arbiter.sv
// Two-requester (audio, graphics) 16-bit read arbiter for a byte-wide parallel flash.
// Define FLASH_ARB_AUD_PRIORITY_EN for strict audio priority; default is round-robin.
module flash_read_arbiter
   import flash_arb_pkg::*;
#(
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
   parameter int ADDR_W      = ADDR_W_DEFAULT
) (
   input  logic              Clk,
   input  logic              Reset_N,
   input  logic              aud_req,
   input  logic [ADDR_W-1:0] aud_addr,
   output logic              aud_ack,
   output logic [15:0]       aud_data,
   input  logic              gfx_req,
   input  logic [ADDR_W-1:0] gfx_addr,
   output logic              gfx_ack,
   output logic [15:0]       gfx_data,
   output logic              busy,
   output logic [ADDR_W-1:0] FL_ADDR,
   input  logic [7:0]        FL_DQ,
   output logic              FL_CE_N,
   output logic              FL_OE_N,
   output logic              FL_WE_N,
   output logic              FL_RST_N,
   output logic              FL_WP_N
);

   localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(WAIT_CYCLES - 1);

   state_t            r_state;
   owner_t            r_owner;
   owner_t            r_last_grant;
   owner_t            w_winner;
   logic [ADDR_W-1:0] w_win_addr;
   logic [ADDR_W-1:0] r_fl_addr;
   logic [7:0]        r_byte0;
   logic [15:0]       r_aud_data;
   logic [15:0]       r_gfx_data;
   logic              r_aud_ack;
   logic              r_gfx_ack;
   logic              r_busy;
   logic              r_ce_n;
   logic              r_oe_n;
   logic              w_req_any;
   logic              w_timer_load;
   logic              w_timer_en;
   logic              w_timer_done;

   always_comb begin
`ifdef FLASH_ARB_AUD_PRIORITY_EN
      w_winner = aud_req ? AUD : GFX;
`else
      w_winner = rr_pick(aud_req, gfx_req, r_last_grant);
`endif
      w_win_addr = (w_winner == AUD) ? aud_addr : gfx_addr;
   end

   assign w_req_any    = aud_req | gfx_req;
   assign w_timer_en   = (r_state == BYTE0) || (r_state == BYTE1);
   // Reload on grant, and again at the end of BYTE0 so the same timer paces BYTE1.
   assign w_timer_load = ((r_state == IDLE) && w_req_any) ||
                         ((r_state == BYTE0) && w_timer_done);

   flash_wait_timer #(.CNT_W(TIMER_W)) u_timer (
      .i_clk      (Clk),
      .i_rst_n    (Reset_N),
      .i_load     (w_timer_load),
      .i_load_val (LOAD_VAL),
      .i_en       (w_timer_en),
      .o_done     (w_timer_done)
   );

   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         r_state      <= IDLE;
         r_owner      <= AUD;
         r_last_grant <= GFX;
         r_fl_addr    <= '0;
         r_byte0      <= '0;
         r_aud_data   <= '0;
         r_gfx_data   <= '0;
         r_aud_ack    <= 1'b0;
         r_gfx_ack    <= 1'b0;
         r_busy       <= 1'b0;
         r_ce_n       <= 1'b1;
         r_oe_n       <= 1'b1;
      end else begin
         r_aud_ack <= 1'b0;
         r_gfx_ack <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_req_any) begin
                  r_owner      <= w_winner;
                  r_last_grant <= w_winner;
                  r_fl_addr    <= w_win_addr;
                  r_ce_n       <= 1'b0;
                  r_oe_n       <= 1'b0;
                  r_busy       <= 1'b1;
                  r_state      <= BYTE0;
               end
            end
            BYTE0: begin
               if (w_timer_done) begin
                  r_byte0   <= FL_DQ;
                  r_fl_addr <= r_fl_addr + ADDR_W'(1);
                  r_state   <= BYTE1;
               end
            end
            BYTE1: begin
               // The ack and data register land together so both are visible in DONE.
               if (w_timer_done) begin
                  if (r_owner == AUD) begin
                     r_aud_ack  <= 1'b1;
                     r_aud_data <= {FL_DQ, r_byte0};
                  end else begin
                     r_gfx_ack  <= 1'b1;
                     r_gfx_data <= {FL_DQ, r_byte0};
                  end
                  r_ce_n  <= 1'b1;
                  r_oe_n  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign aud_ack  = r_aud_ack;
   assign aud_data = r_aud_data;
   assign gfx_ack  = r_gfx_ack;
   assign gfx_data = r_gfx_data;
   assign busy     = r_busy;
   assign FL_ADDR  = r_fl_addr;
   assign FL_CE_N  = r_ce_n;
   assign FL_OE_N  = r_oe_n;
   assign FL_WE_N  = 1'b1;
   assign FL_RST_N = 1'b1;
   assign FL_WP_N  = 1'b1;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Randomized self-checking bench for flash_read_arbiter against a transaction-level scheduler model.
// Expectations follow FLASH_ARB_AUD_PRIORITY_EN when it is defined for the build.
module tb_flash_read_arbiter;

   localparam int W   = 4;
   localparam int AW  = 23;
   localparam int ACC = 2 * W + 2;

   logic          Clk = 1'b0;
   logic          Reset_N = 1'b0;
   logic          aud_req = 1'b0;
   logic [AW-1:0] aud_addr = '0;
   logic          aud_ack;
   logic [15:0]   aud_data;
   logic          gfx_req = 1'b0;
   logic [AW-1:0] gfx_addr = '0;
   logic          gfx_ack;
   logic [15:0]   gfx_data;
   logic          busy;
   logic [AW-1:0] FL_ADDR;
   logic [7:0]    FL_DQ = 8'hEE;
   logic          FL_CE_N, FL_OE_N, FL_WE_N, FL_RST_N, FL_WP_N;

   flash_read_arbiter #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
      .Clk(Clk), .Reset_N(Reset_N),
      .aud_req(aud_req), .aud_addr(aud_addr), .aud_ack(aud_ack), .aud_data(aud_data),
      .gfx_req(gfx_req), .gfx_addr(gfx_addr), .gfx_ack(gfx_ack), .gfx_data(gfx_data),
      .busy(busy), .FL_ADDR(FL_ADDR), .FL_DQ(FL_DQ),
      .FL_CE_N(FL_CE_N), .FL_OE_N(FL_OE_N), .FL_WE_N(FL_WE_N),
      .FL_RST_N(FL_RST_N), .FL_WP_N(FL_WP_N)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int          who;
      int          t;
      logic [15:0] d;
      logic [15:0] o;
   } ev_t;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            base_cyc = 0;
   int            age = 0;
   logic [AW-1:0] prev_addr = '0;
   ev_t           obs[$];
   ev_t           exp_q[$];
   logic [AW-1:0] a_addrs[8];
   logic [AW-1:0] g_addrs[8];
   logic [AW-1:0] log_addr[4096];
   logic          log_ce[4096];
   logic          log_busy[4096];

   function automatic logic [7:0] fl_byte(input logic [AW-1:0] a);
      if (a == 23'h000100) return 8'h34;
      if (a == 23'h000101) return 8'h12;
      return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h5A;
   endfunction

   always @(posedge Clk) cyc <= cyc + 1;

   // Flash model: data is only valid once the address has been stable for W cycles with CE/OE low.
   always @(negedge Clk) begin : mon
      int  nage;
      ev_t e;
      nage = (FL_ADDR !== prev_addr) ? 1 : age + 1;
      age       <= nage;
      prev_addr <= FL_ADDR;
      FL_DQ     <= (!FL_CE_N && !FL_OE_N && nage >= W) ? fl_byte(FL_ADDR) : 8'hEE;
      log_addr[cyc & 4095] <= FL_ADDR;
      log_ce[cyc & 4095]   <= FL_CE_N;
      log_busy[cyc & 4095] <= busy;
      if (aud_ack) begin
         e.who = 0; e.t = cyc; e.d = aud_data; e.o = gfx_data;
         obs.push_back(e);
      end
      if (gfx_ack) begin
         e.who = 1; e.t = cyc; e.d = gfx_data; e.o = aud_data;
         obs.push_back(e);
      end
   end

   task automatic do_reset();
      @(negedge Clk);
      Reset_N = 1'b0;
      aud_req = 1'b0;
      gfx_req = 1'b0;
      repeat (2) @(negedge Clk);
      Reset_N = 1'b1;
      @(negedge Clk);
      obs.delete();
   endtask

   // Requesters hold req until their last ack, presenting the next address in the ack cycle.
   task automatic run_traffic(input int sa, input int na, input int sg, input int ng, input int budget);
      int ai = 0;
      int gi = 0;
      for (int k = 0; k < budget; k++) begin
         @(negedge Clk);
         if (k == 0) base_cyc = cyc;
         if (aud_req && aud_ack) begin
            ai++;
            if (ai >= na) aud_req = 1'b0; else aud_addr = a_addrs[ai];
         end
         if (gfx_req && gfx_ack) begin
            gi++;
            if (gi >= ng) gfx_req = 1'b0; else gfx_addr = g_addrs[gi];
         end
         if (k == sa && na > 0) begin aud_req = 1'b1; aud_addr = a_addrs[0]; end
         if (k == sg && ng > 0) begin gfx_req = 1'b1; gfx_addr = g_addrs[0]; end
      end
   endtask

   // Scheduler model: each grant occupies ACC cycles; ack lands 2W+1 cycles after the grant decision.
   task automatic build_model(input int sa, input int na, input int sg, input int ng);
      int ra = na, rg = ng, ia = 0, ig = 0, last = 1, w = 0, tt;
      int ta = base_cyc + sa;
      int tg = base_cyc + sg;
      logic [15:0] da = '0, dg = '0, d;
      logic [AW-1:0] a, a1;
      bit pa, pg;
      ev_t e;
      exp_q.delete();
      tt = (na > 0) ? ta : tg;
      if (na > 0 && ng > 0 && tg < ta) tt = tg;
      while (ra > 0 || rg > 0) begin
         pa = (ra > 0) && (ta <= tt);
         pg = (rg > 0) && (tg <= tt);
         if (!pa && !pg) begin
            tt = (ra > 0) ? ta : tg;
            if (ra > 0 && rg > 0 && tg < ta) tt = tg;
            continue;
         end
`ifdef FLASH_ARB_AUD_PRIORITY_EN
         w = pa ? 0 : 1;
`else
         if (pa && pg) w = (last == 0) ? 1 : 0;
         else          w = pa ? 0 : 1;
`endif
         last = w;
         a  = (w == 0) ? a_addrs[ia] : g_addrs[ig];
         a1 = a + 1'b1;
         d  = {fl_byte(a1), fl_byte(a)};
         e.who = w; e.t = tt + 2 * W + 1; e.d = d;
         if (w == 0) begin
            e.o = dg; da = d; ra--; ia++; ta = tt + ACC;
         end else begin
            e.o = da; dg = d; rg--; ig++; tg = tt + ACC;
         end
         exp_q.push_back(e);
         tt += ACC;
      end
   endtask

   task automatic test_reset();
      logic [7:0] got;
      repeat (2) @(negedge Clk);
      got = {busy, FL_CE_N, FL_OE_N, FL_WE_N, FL_RST_N, FL_WP_N, aud_ack, gfx_ack};
      checks++;
      if (got !== 8'b0111_1100) begin
         errors++; $display("FAIL reset_ctrl actual=%b expected=%b", got, 8'b0111_1100);
      end
      checks++;
      if (FL_ADDR !== '0) begin errors++; $display("FAIL reset_addr actual=%h expected=0", FL_ADDR); end
      checks++;
      if (aud_data !== 16'h0 || gfx_data !== 16'h0) begin
         errors++; $display("FAIL reset_data actual=%h/%h expected=0/0", aud_data, gfx_data);
      end
      Reset_N = 1'b1;
      @(negedge Clk);
   endtask

   task automatic test_basic();
      do_reset();
      a_addrs[0] = 23'h000100;
      run_traffic(0, 1, 0, 0, ACC + 4);
      checks++;
      if (obs.size() != 1) begin
         errors++; $display("FAIL basic_count actual=%0d expected=1", obs.size());
      end else begin
         checks++;
         if (obs[0].who !== 0 || obs[0].t !== base_cyc + 2 * W + 1) begin
            errors++; $display("FAIL basic_latency actual=who%0d@%0d expected=who0@%0d", obs[0].who, obs[0].t, base_cyc + 2 * W + 1);
         end
         checks++;
         if (obs[0].d !== 16'h1234) begin errors++; $display("FAIL basic_data actual=%h expected=1234", obs[0].d); end
      end
      checks++;
      if (gfx_data !== 16'h0) begin errors++; $display("FAIL basic_gfx_untouched actual=%h expected=0", gfx_data); end
      checks++;
      if ({log_busy[base_cyc & 4095], log_busy[(base_cyc + 1) & 4095], log_busy[(base_cyc + 2 * W + 1) & 4095],
           log_busy[(base_cyc + ACC) & 4095]} !== 4'b0110) begin
         errors++; $display("FAIL basic_busy actual=%b%b%b%b expected=0110", log_busy[base_cyc & 4095],
                            log_busy[(base_cyc + 1) & 4095], log_busy[(base_cyc + 2 * W + 1) & 4095], log_busy[(base_cyc + ACC) & 4095]);
      end
   endtask

   task automatic test_wrap();
      logic [AW-1:0] top = '1;
      logic [AW-1:0] zero = '0;
      do_reset();
      a_addrs[0] = top;
      run_traffic(0, 1, 0, 0, ACC + 4);
      checks++;
      if (log_addr[(base_cyc + 1) & 4095] !== top) begin
         errors++; $display("FAIL wrap_byte0_addr actual=%h expected=%h", log_addr[(base_cyc + 1) & 4095], top);
      end
      checks++;
      if (log_addr[(base_cyc + W + 1) & 4095] !== zero) begin
         errors++; $display("FAIL wrap_byte1_addr actual=%h expected=0", log_addr[(base_cyc + W + 1) & 4095]);
      end
      checks++;
      if (aud_data !== {fl_byte(zero), fl_byte(top)}) begin
         errors++; $display("FAIL wrap_data actual=%h expected=%h", aud_data, {fl_byte(zero), fl_byte(top)});
      end
      checks++;
      if (FL_ADDR !== zero) begin errors++; $display("FAIL wrap_addr_hold actual=%h expected=0", FL_ADDR); end
   endtask

   task automatic test_arbitration();
      int order_exp[6];
`ifdef FLASH_ARB_AUD_PRIORITY_EN
      order_exp = '{0, 0, 0, 1, 1, 1};
`else
      order_exp = '{0, 1, 0, 1, 0, 1};
`endif
      do_reset();
      for (int i = 0; i < 3; i++) begin
         a_addrs[i] = AW'($urandom);
         g_addrs[i] = AW'($urandom);
      end
      run_traffic(0, 3, 0, 3, 6 * ACC + 6);
      build_model(0, 3, 0, 3);
      checks++;
      if (obs.size() != exp_q.size()) begin
         errors++; $display("FAIL arb_count actual=%0d expected=%0d", obs.size(), exp_q.size());
      end
      for (int i = 0; i < 6 && i < obs.size(); i++) begin
         checks++;
         if (obs[i].who !== order_exp[i]) begin
            errors++; $display("FAIL arb_order%0d actual=%0d expected=%0d", i, obs[i].who, order_exp[i]);
         end
      end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         checks++;
         if (obs[i].who !== exp_q[i].who || obs[i].t !== exp_q[i].t || obs[i].d !== exp_q[i].d || obs[i].o !== exp_q[i].o) begin
            errors++; $display("FAIL arb_ev%0d actual who=%0d t=%0d d=%h o=%h expected who=%0d t=%0d d=%h o=%h", i,
                               obs[i].who, obs[i].t, obs[i].d, obs[i].o, exp_q[i].who, exp_q[i].t, exp_q[i].d, exp_q[i].o);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [AW-1:0] a1, a2;
      logic [15:0]   d1;
      int            s;
      logic [6:0]    got;
      do_reset();
      a1 = AW'($urandom);
      a2 = AW'($urandom);
      a_addrs[0] = a1;
      run_traffic(0, 1, 0, 0, ACC + 2);
      d1 = {fl_byte(a1 + 1'b1), fl_byte(a1)};
      checks++;
      if (aud_data !== d1) begin errors++; $display("FAIL rmid_first_data actual=%h expected=%h", aud_data, d1); end
      @(negedge Clk);
      aud_addr = a2;
      aud_req  = 1'b1;
      s = cyc;
      repeat (W + 1) @(negedge Clk);
      checks++;
      if (FL_ADDR !== a2 + 1'b1) begin errors++; $display("FAIL rmid_in_byte1 actual=%h expected=%h", FL_ADDR, a2 + 1'b1); end
      Reset_N = 1'b0;
      aud_req = 1'b0;
      obs.delete();
      #1;
      got = {busy, FL_CE_N, FL_OE_N, aud_ack, gfx_ack, |aud_data, |FL_ADDR};
      checks++;
      if (got !== 7'b0110000) begin errors++; $display("FAIL rmid_async_reset actual=%b expected=0110000", got); end
      repeat (2) @(negedge Clk);
      Reset_N = 1'b1;
      repeat (ACC + 4) @(negedge Clk);
      checks++;
      if (obs.size() != 0 || busy !== 1'b0) begin
         errors++; $display("FAIL rmid_no_ack actual=acks%0d busy%b expected=acks0 busy0 (from %0d)", obs.size(), busy, s);
      end
      a_addrs[0] = a2;
      run_traffic(0, 1, 0, 0, ACC + 4);
      checks++;
      if (obs.size() != 1) begin
         errors++; $display("FAIL rmid_resume_count actual=%0d expected=1", obs.size());
      end else if (obs[0].t !== base_cyc + 2 * W + 1 || obs[0].d !== {fl_byte(a2 + 1'b1), fl_byte(a2)}) begin
         errors++; $display("FAIL rmid_resume actual=%h@%0d expected=%h@%0d", obs[0].d, obs[0].t,
                            {fl_byte(a2 + 1'b1), fl_byte(a2)}, base_cyc + 2 * W + 1);
      end
   endtask

   task automatic test_back_to_back();
      int  rel;
      logic exp_ce;
      do_reset();
      for (int i = 0; i < 4; i++) g_addrs[i] = AW'($urandom);
      run_traffic(0, 0, 0, 4, 4 * ACC + 4);
      checks++;
      if (obs.size() != 4) begin errors++; $display("FAIL b2b_count actual=%0d expected=4", obs.size()); end
      for (int i = 0; i < 4 && i < obs.size(); i++) begin
         checks++;
         if (obs[i].who !== 1 || obs[i].t !== base_cyc + 2 * W + 1 + i * ACC ||
             obs[i].d !== {fl_byte(g_addrs[i] + 1'b1), fl_byte(g_addrs[i])}) begin
            errors++; $display("FAIL b2b_ack%0d actual=who%0d %h@%0d expected=who1 %h@%0d", i, obs[i].who, obs[i].d, obs[i].t,
                               {fl_byte(g_addrs[i] + 1'b1), fl_byte(g_addrs[i])}, base_cyc + 2 * W + 1 + i * ACC);
         end
      end
      for (int c = base_cyc; c < base_cyc + 4 * ACC; c++) begin
         rel = (c - base_cyc) % ACC;
         exp_ce = (rel == 0 || rel == 2 * W + 1);
         checks++;
         if (log_ce[c & 4095] !== exp_ce) begin
            errors++; $display("FAIL b2b_ce cycle+%0d actual=%b expected=%b", c - base_cyc, log_ce[c & 4095], exp_ce);
         end
      end
   endtask

   task automatic test_drop();
      logic [AW-1:0] a;
      int s;
      bit idle_ok = 1'b1;
      do_reset();
      a = AW'($urandom);
      @(negedge Clk);
      aud_addr = a;
      aud_req  = 1'b1;
      s = cyc;
      repeat (2) @(negedge Clk);
      aud_req = 1'b0;
      repeat (2 * ACC + 4) @(negedge Clk);
      checks++;
      if (obs.size() != 1) begin
         errors++; $display("FAIL drop_count actual=%0d expected=1", obs.size());
      end else if (obs[0].t !== s + 2 * W + 1 || obs[0].d !== {fl_byte(a + 1'b1), fl_byte(a)}) begin
         errors++; $display("FAIL drop_ack actual=%h@%0d expected=%h@%0d", obs[0].d, obs[0].t,
                            {fl_byte(a + 1'b1), fl_byte(a)}, s + 2 * W + 1);
      end
      for (int c = s + ACC; c < s + 2 * ACC; c++) if (log_busy[c & 4095] !== 1'b0) idle_ok = 1'b0;
      checks++;
      if (!idle_ok) begin errors++; $display("FAIL drop_stays_idle actual=busy expected=idle"); end
   endtask

   task automatic test_random();
      int na, ng, sa, sg;
      for (int it = 0; it < 8; it++) begin
         do_reset();
         for (int i = 0; i < 8; i++) begin
            a_addrs[i] = AW'($urandom);
            g_addrs[i] = AW'($urandom);
         end
         if (it == 0) a_addrs[0] = '1;
         na = $urandom_range(0, 3);
         ng = $urandom_range(1, 3);
         sa = $urandom_range(0, 3);
         sg = $urandom_range(0, 3);
         run_traffic(sa, na, sg, ng, (na + ng) * ACC + 8);
         build_model(sa, na, sg, ng);
         checks++;
         if (obs.size() != exp_q.size()) begin
            errors++; $display("FAIL rnd%0d_count actual=%0d expected=%0d", it, obs.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i].who !== exp_q[i].who || obs[i].t !== exp_q[i].t || obs[i].d !== exp_q[i].d || obs[i].o !== exp_q[i].o) begin
               errors++; $display("FAIL rnd%0d_ev%0d actual who=%0d t=%0d d=%h o=%h expected who=%0d t=%0d d=%h o=%h", it, i,
                                  obs[i].who, obs[i].t, obs[i].d, obs[i].o, exp_q[i].who, exp_q[i].t, exp_q[i].d, exp_q[i].o);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_arbitration();
      test_reset_mid();
      test_back_to_back();
      test_drop();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired actual=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
